fetch_queue: RTL and testbench

//   Instruction fetch stage upstream of the mips core datapath. Owns the fetch PC,

---
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, reads instruction memory over
// req/ack and queues {pc, instr} pairs for decode; a redirect flushes and restarts.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   queue_count
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for queue space
  // REQ   | request outstanding, returned data is pushed
  // DROP  | request outstanding, returned data is discarded after a redirect
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t            state;
  state_t            state_next;
  logic [31:0]       fetch_pc;
  logic [31:0]       drop_addr;
  logic [31:0]       fifo_pc    [DEPTH];
  logic [31:0]       fifo_instr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic              has_room;
  logic              redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    pop        = (count != '0) && instr_ready;
    push       = (state == REQ) && imem_ack && !redirect_valid;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    has_room   = (count_next < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && has_room) begin
          state_next = REQ;
        end
      end
      REQ: begin
        // a redirect racing an ack simply drops that data and refetches
        if (redirect_valid) begin
          state_next = imem_ack ? REQ : DROP;
        end else if (imem_ack) begin
          state_next = has_room ? REQ : IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc  <= RESET_PC;
      drop_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // keep the abandoned address on the bus until memory acks it
      if (state == REQ && !imem_ack) begin
        drop_addr <= fetch_pc;
      end
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = (state != IDLE);
  assign imem_addr   = (state == DROP) ? drop_addr : fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;
  assign queue_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue against a queue-based model
// of the fetch rules (pending request, discard flag, FIFO contents).
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  queue_count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_hold = RESET_PC;
  bit          m_busy = 1'b0;
  bit          m_discard = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 0;
  int rdy_mode = 1;
  int wait_cnt = 0;
  bit data_rand = 1'b0;

  function automatic logic [31:0] exp_addr();
    return m_discard ? m_hold : m_pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit fire;
    bit pop_pre;
    if (!reset) begin
      q.delete();
      m_pc      = RESET_PC;
      m_hold    = RESET_PC;
      m_busy    = 1'b0;
      m_discard = 1'b0;
    end else if (redirect_valid) begin
      q.delete();
      if (m_busy && !imem_ack) begin
        if (!m_discard) m_hold = m_pc;
        m_discard = 1'b1;
      end else begin
        m_discard = 1'b0;
      end
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      ent_t e;
      fire    = m_busy && imem_ack;
      pop_pre = (q.size() > 0) && instr_ready;
      if (pop_pre) void'(q.pop_front());
      if (fire && !m_discard) begin
        e.pc  = m_pc;
        e.ins = imem_rdata;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
      if (fire && m_discard) m_discard = 1'b0;
      else if (fire || !m_busy) m_busy = (q.size() < DEPTH);
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0);
    chk("imem_req",    32'(imem_req),    32'(m_busy));
    chk("imem_addr",   imem_addr,        exp_addr());
    chk("instr_valid", 32'(instr_valid), 32'(v));
    chk("instr",       instr,            v ? q[0].ins : 32'h0);
    chk("instr_pc",    instr_pc,         v ? q[0].pc : 32'h0);
    chk("queue_count", 32'(queue_count), 32'(q.size()));
  endtask

  task automatic step(input logic rst_n, input logic redir, input logic [31:0] rpc);
    logic ack;
    if (ack_delay < 0) ack = ($urandom_range(0, 2) == 0);
    else               ack = m_busy && (wait_cnt >= ack_delay);
    reset          = rst_n;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ack       = ack;
    instr_ready    = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    imem_rdata     = data_rand ? $urandom : exp_addr();
    if (!rst_n || !m_busy || ack) wait_cnt = 0;
    else wait_cnt++;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    // zero-wait memory returning the address, consumer always ready
    ack_delay = 0; rdy_mode = 1; data_rand = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("reset_addr", imem_addr, RESET_PC);
    step(1'b1, 1'b0, 32'h0);
    chk("first_not_yet", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("first_pc", instr_pc, 32'h3000);
    step(1'b1, 1'b0, 32'h0);
    chk("second_pc", instr_pc, 32'h3004);
    run(10);

    // consumer stalled: queue fills to DEPTH and fetch stops
    rdy_mode = 0;
    step(1'b0, 1'b0, 32'h0);
    run(8);
    chk("full_count", 32'(queue_count), 32'd4);
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_next_addr", imem_addr, 32'h3010);
    rdy_mode = 1;
    run(8);

    // three wait states per access, random ready and data
    ack_delay = 3; rdy_mode = 2; data_rand = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    run(30);

    // redirect while a request is pending: old data dropped
    rdy_mode = 0;
    step(1'b0, 1'b0, 32'h0);
    run(2);
    step(1'b1, 1'b1, 32'h0000_3403);
    chk("drop_addr_held", imem_addr, 32'h3000);
    chk("drop_count", 32'(queue_count), 32'd0);
    run(6);
    chk("redirect_pc", instr_pc, 32'h3400);

    // redirect, pop and ack together with two entries queued
    ack_delay = 0; rdy_mode = 0;
    step(1'b0, 1'b0, 32'h0);
    run(3);
    chk("pre_flush_count", 32'(queue_count), 32'd2);
    rdy_mode = 1;
    step(1'b1, 1'b1, 32'h0000_5000);
    chk("flush_count", 32'(queue_count), 32'd0);
    chk("flush_addr", imem_addr, 32'h5000);
    run(1);
    chk("after_flush_pc", instr_pc, 32'h5000);

    // fetch PC wraps past the top of the address space
    rdy_mode = 0;
    step(1'b0, 1'b0, 32'h0);
    run(1);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    run(2);
    chk("wrap_head", instr_pc, 32'hFFFF_FFFC);
    rdy_mode = 1;
    run(1);
    chk("wrap_pc", instr_pc, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0);
    chk("midreset_req", 32'(imem_req), 32'd0);
    chk("midreset_count", 32'(queue_count), 32'd0);
    chk("midreset_addr", imem_addr, RESET_PC);

    // random traffic: stray acks, random ready, occasional redirect and reset
    ack_delay = -1; rdy_mode = 2; data_rand = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
